// File: rtl/pmu_spi_cmd_seq.sv
// rtl/pmu_spi_cmd_seq.sv - PMU SPI command sequencer: FIFO-buffered host commands issued to the SPI driver
//
// Buffers {cmd_rd, cmd_data} host commands and issues them one at a time to
// spi_drive_top over its wr_req/rd_req/ready handshake. Each transaction is
// guarded by a completion timeout. Read commands produce a one-cycle response.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready         host command handshake (cmd_ready = !full)
//   cmd_rd, cmd_data            command type (1 = read) and SPI word
//   spi_wr_req, spi_rd_req      one-cycle requests to the driver
//   spi_data                    word presented to the driver
//   spi_ready                   driver idle
//   spi_wr_done                 driver write completion pulse
//   spi_rd_data_vld             driver readback valid pulse
//   spi_rd_data, spi_rd_data_b  readback words, devices A and B
//   rsp_valid                   one-cycle read response strobe
//   rsp_data, rsp_data_b        response words (held until next response)
//   rsp_timeout                 response is a timed-out read
//   err_timeout, err_clr        sticky timeout flag and its clear
//   fifo_level                  FIFO occupancy
//   busy                        FSM active or FIFO non-empty
module pmu_spi_cmd_seq #(
  parameter int DATA_WITH      = 29,
  parameter int READ_DATA_WITH = 29,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT        = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_rd,
  input  logic [DATA_WITH-1:0]          cmd_data,
  output logic                          spi_wr_req,
  output logic                          spi_rd_req,
  output logic [DATA_WITH-1:0]          spi_data,
  input  logic                          spi_ready,
  input  logic                          spi_wr_done,
  input  logic                          spi_rd_data_vld,
  input  logic [READ_DATA_WITH-1:0]     spi_rd_data,
  input  logic [READ_DATA_WITH-1:0]     spi_rd_data_b,
  output logic                          rsp_valid,
  output logic [READ_DATA_WITH-1:0]     rsp_data,
  output logic [READ_DATA_WITH-1:0]     rsp_data_b,
  output logic                          rsp_timeout,
  output logic                          err_timeout,
  input  logic                          err_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_REQ   = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  logic [DATA_WITH:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               full;
  logic               push;
  logic               pop;
  logic [1:0]         state;
  logic               cur_rd;
  logic [CW-1:0]      cnt;
  logic               term;

  assign full      = (fifo_level == LW'(FIFO_DEPTH));
  assign cmd_ready = !full;
  // A full FIFO refuses the push even if IDLE pops in the same cycle.
  assign push      = cmd_valid && !full;
  assign pop       = (state == S_IDLE) && (fifo_level != '0);
  assign busy      = (state != S_IDLE) || (fifo_level != '0);
  assign term      = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_rd, cmd_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cur_rd      <= 1'b0;
      cnt         <= '0;
      spi_data    <= '0;
      spi_wr_req  <= 1'b0;
      spi_rd_req  <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_data_b  <= '0;
      rsp_timeout <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      rsp_valid  <= 1'b0;
      spi_wr_req <= 1'b0;
      spi_rd_req <= 1'b0;
      // Clear first so a timeout set later in this block takes priority.
      if (err_clr) err_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            spi_data <= mem[rd_ptr][DATA_WITH-1:0];
            cur_rd   <= mem[rd_ptr][DATA_WITH];
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Requests are raised here so they are high exactly during REQ.
          if (spi_ready) begin
            spi_rd_req <= cur_rd;
            spi_wr_req <= !cur_rd;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        default: begin
          // Completion is checked before the terminal count so it wins a tie.
          if (cur_rd && spi_rd_data_vld) begin
            rsp_valid   <= 1'b1;
            rsp_data    <= spi_rd_data;
            rsp_data_b  <= spi_rd_data_b;
            rsp_timeout <= 1'b0;
            state       <= S_IDLE;
          end else if (!cur_rd && spi_wr_done) begin
            state <= S_IDLE;
          end else if (term) begin
            err_timeout <= 1'b1;
            if (cur_rd) begin
              rsp_valid   <= 1'b1;
              rsp_data    <= '0;
              rsp_data_b  <= '0;
              rsp_timeout <= 1'b1;
            end
            state <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmu_spi_cmd_seq.sv
// tb/tb_pmu_spi_cmd_seq.sv - directed self-checking bench for pmu_spi_cmd_seq
module tb_pmu_spi_cmd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_rd = 1'b0;
  logic [28:0] cmd_data = '0;
  logic        spi_wr_req;
  logic        spi_rd_req;
  logic [28:0] spi_data;
  logic        spi_ready = 1'b0;
  logic        spi_wr_done = 1'b0;
  logic        spi_rd_data_vld = 1'b0;
  logic [28:0] spi_rd_data = '0;
  logic [28:0] spi_rd_data_b = '0;
  logic        rsp_valid;
  logic [28:0] rsp_data;
  logic [28:0] rsp_data_b;
  logic        rsp_timeout;
  logic        err_timeout;
  logic        err_clr = 1'b0;
  logic [3:0]  fifo_level;
  logic        busy;

  int checks = 0;
  int errors = 0;

  pmu_spi_cmd_seq #(
    .DATA_WITH(29), .READ_DATA_WITH(29), .FIFO_DEPTH(8), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd), .cmd_data(cmd_data),
    .spi_wr_req(spi_wr_req), .spi_rd_req(spi_rd_req), .spi_data(spi_data),
    .spi_ready(spi_ready), .spi_wr_done(spi_wr_done), .spi_rd_data_vld(spi_rd_data_vld),
    .spi_rd_data(spi_rd_data), .spi_rd_data_b(spi_rd_data_b),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_data_b(rsp_data_b),
    .rsp_timeout(rsp_timeout), .err_timeout(err_timeout), .err_clr(err_clr),
    .fifo_level(fifo_level), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (spi_wr_req || spi_rd_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if ({spi_wr_req, spi_rd_req, rsp_valid, rsp_timeout, err_timeout} !== 5'b0)
      begin errors++; $display("FAIL reset_flags got %b exp 00000", {spi_wr_req, spi_rd_req, rsp_valid, rsp_timeout, err_timeout}); end
    checks++; if (spi_data !== 29'd0) begin errors++; $display("FAIL reset_spi_data got %h exp 0", spi_data); end
  endtask

  task automatic test_write();
    spi_ready = 1'b1;
    cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_data = 29'h1234567;
    tick();  // N+1
    cmd_valid = 1'b0;
    checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL write_level got %0d exp 1", fifo_level); end
    tick();  // N+2, ISSUE
    checks++; if (spi_wr_req !== 1'b0) begin errors++; $display("FAIL write_req_early got %b exp 0", spi_wr_req); end
    tick();  // N+3, REQ
    checks++; if (spi_wr_req !== 1'b1 || spi_rd_req !== 1'b0)
      begin errors++; $display("FAIL write_req got wr=%b rd=%b exp wr=1 rd=0", spi_wr_req, spi_rd_req); end
    checks++; if (spi_data !== 29'h1234567) begin errors++; $display("FAIL write_data got %h exp 1234567", spi_data); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (spi_wr_req !== 1'b0 || busy !== 1'b1)
        begin errors++; $display("FAIL write_wait got req=%b busy=%b exp req=0 busy=1", spi_wr_req, busy); end
    end
    spi_wr_done = 1'b1;
    tick();
    spi_wr_done = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_end got %b exp 0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL write_no_rsp got %b exp 0", rsp_valid); end
  endtask

  task automatic test_read();
    bit ok;
    spi_ready = 1'b1;
    cmd_valid = 1'b1; cmd_rd = 1'b1; cmd_data = 29'h0000055;
    tick();
    cmd_valid = 1'b0;
    wait_req(ok);
    checks++; if (!ok || spi_rd_req !== 1'b1 || spi_wr_req !== 1'b0)
      begin errors++; $display("FAIL read_req got ok=%b rd=%b wr=%b exp 1 1 0", ok, spi_rd_req, spi_wr_req); end
    tick();  // WAIT
    spi_rd_data = 29'h0ABCDEF; spi_rd_data_b = 29'h1555555; spi_rd_data_vld = 1'b1;
    tick();
    spi_rd_data_vld = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0)
      begin errors++; $display("FAIL read_rsp got valid=%b to=%b exp 1 0", rsp_valid, rsp_timeout); end
    checks++; if (rsp_data !== 29'h0ABCDEF || rsp_data_b !== 29'h1555555)
      begin errors++; $display("FAIL read_data got %h/%h exp 0abcdef/1555555", rsp_data, rsp_data_b); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy got %b exp 0", busy); end
    tick();
    checks++; if (rsp_valid !== 1'b0 || rsp_data !== 29'h0ABCDEF)
      begin errors++; $display("FAIL read_hold got valid=%b data=%h exp 0 0abcdef", rsp_valid, rsp_data); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [28:0] exp_data [9];
    bit          exp_rd [9];
    spi_ready = 1'b0;
    exp_data[0] = 29'h0AAAAAA; exp_rd[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_data[i+1] = 29'h100 + 29'(i);
      exp_rd[i+1]   = i[0];
    end
    // Park one command in ISSUE so the FIFO itself fills to 8.
    cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_data = exp_data[0];
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 9; i++) begin
      cmd_valid = 1'b1; cmd_rd = i[0]; cmd_data = 29'h100 + 29'(i);
      checks++; if (cmd_ready !== (i < 8))
        begin errors++; $display("FAIL b2b_cmd_ready[%0d] got %b exp %b", i, cmd_ready, (i < 8)); end
      tick();
    end
    cmd_valid = 1'b0;
    checks++; if (fifo_level !== 4'd8 || cmd_ready !== 1'b0)
      begin errors++; $display("FAIL b2b_full got level=%0d ready=%b exp 8 0", fifo_level, cmd_ready); end
    spi_ready = 1'b1;
    for (int j = 0; j < 9; j++) begin
      wait_req(ok);
      checks++; if (!ok || spi_data !== exp_data[j] || spi_rd_req !== exp_rd[j] || spi_wr_req !== !exp_rd[j])
        begin errors++; $display("FAIL b2b_issue[%0d] got ok=%b data=%h rd=%b wr=%b exp data=%h rd=%b", j, ok, spi_data, spi_rd_req, spi_wr_req, exp_data[j], exp_rd[j]); end
      tick();
      if (exp_rd[j]) begin spi_rd_data = exp_data[j] ^ 29'h1F0F0F0; spi_rd_data_vld = 1'b1; end
      else spi_wr_done = 1'b1;
      tick();
      spi_rd_data_vld = 1'b0; spi_wr_done = 1'b0;
      if (exp_rd[j]) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== (exp_data[j] ^ 29'h1F0F0F0))
          begin errors++; $display("FAIL b2b_rsp[%0d] got valid=%b data=%h exp 1 %h", j, rsp_valid, rsp_data, exp_data[j] ^ 29'h1F0F0F0); end
      end
    end
    checks++; if (fifo_level !== 4'd0 || busy !== 1'b0)
      begin errors++; $display("FAIL b2b_drain got level=%0d busy=%b exp 0 0", fifo_level, busy); end
  endtask

  task automatic test_timeout();
    bit ok;
    spi_ready = 1'b1;
    spi_rd_data = 29'h1111111; spi_rd_data_b = 29'h0222222;
    cmd_valid = 1'b1; cmd_rd = 1'b1; cmd_data = 29'h0000077;
    tick();
    cmd_valid = 1'b0;
    wait_req(ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_req got 0 exp 1"); end
    for (int k = 0; k < 16; k++) tick();  // WAIT cycles with count 0..15
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1)
      begin errors++; $display("FAIL to_early got valid=%b busy=%b exp 0 1", rsp_valid, busy); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || err_timeout !== 1'b1)
      begin errors++; $display("FAIL to_rsp got valid=%b to=%b err=%b exp 1 1 1", rsp_valid, rsp_timeout, err_timeout); end
    checks++; if (rsp_data !== 29'd0 || rsp_data_b !== 29'd0)
      begin errors++; $display("FAIL to_data got %h/%h exp 0/0", rsp_data, rsp_data_b); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_clr got %b exp 0", err_timeout); end
    // Completion on the terminal count cycle is a normal response.
    cmd_valid = 1'b1; cmd_rd = 1'b1; cmd_data = 29'h0000078;
    tick();
    cmd_valid = 1'b0;
    wait_req(ok);
    checks++; if (!ok) begin errors++; $display("FAIL term_req got 0 exp 1"); end
    for (int k = 0; k < 16; k++) tick();
    spi_rd_data = 29'h0123456; spi_rd_data_b = 29'h0654321; spi_rd_data_vld = 1'b1;
    tick();
    spi_rd_data_vld = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || err_timeout !== 1'b0)
      begin errors++; $display("FAIL term_rsp got valid=%b to=%b err=%b exp 1 0 0", rsp_valid, rsp_timeout, err_timeout); end
    checks++; if (rsp_data !== 29'h0123456 || rsp_data_b !== 29'h0654321)
      begin errors++; $display("FAIL term_data got %h/%h exp 0123456/0654321", rsp_data, rsp_data_b); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    spi_ready = 1'b1;
    cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_data = 29'h0000999;
    tick();
    cmd_valid = 1'b0;
    wait_req(ok);
    tick();  // WAIT
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_rd = 1'b1; cmd_data = 29'h200 + 29'(i);
      tick();
    end
    cmd_valid = 1'b0;
    checks++; if (!ok || fifo_level !== 4'd3)
      begin errors++; $display("FAIL mid_level got ok=%b level=%0d exp 1 3", ok, fifo_level); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (fifo_level !== 4'd0 || busy !== 1'b0 || cmd_ready !== 1'b1)
      begin errors++; $display("FAIL mid_rst got level=%0d busy=%b ready=%b exp 0 0 1", fifo_level, busy, cmd_ready); end
    checks++; if ({spi_wr_req, spi_rd_req, rsp_valid} !== 3'b0)
      begin errors++; $display("FAIL mid_rst_out got %b exp 000", {spi_wr_req, spi_rd_req, rsp_valid}); end
    spi_wr_done = 1'b1;
    tick();
    spi_wr_done = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || {spi_wr_req, spi_rd_req, rsp_valid, err_timeout} !== 4'b0)
      begin errors++; $display("FAIL mid_stray got busy=%b out=%b exp 0 0000", busy, {spi_wr_req, spi_rd_req, rsp_valid, err_timeout}); end
  endtask

  initial begin
    #1;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pmu_spi_cmd_seq.md
# pmu_spi_cmd_seq

Command sequencer directly upstream of the PMU SPI driver (`spi_drive_top`). Buffers host register write/read commands in a FIFO and issues them one at a time over the driver's `wr_req`/`rd_req`/`ready` handshake. Returns dual-device readback words (`rd_data`, `rd_data_b`) as single-cycle responses. Guards each transaction with a completion timeout.

## Interface

Parameters:
- `DATA_WITH`, 29, command word width; must match the driver's `DATA_WITH`.
- `READ_DATA_WITH`, 29, readback width; must match the driver's `READ_DATA_WITH`.
- `FIFO_DEPTH`, 8, command FIFO entries; power of two, at least 2.
- `TIMEOUT`, 4096, maximum `clk` cycles spent in WAIT per transaction; at least 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  host command valid.
- `cmd_ready`  out  1  FIFO can accept a command; equals `!full`.
- `cmd_rd`  in  1  1 = read command, 0 = write command.
- `cmd_data`  in  DATA_WITH  word to send over SPI.
- `spi_wr_req`  out  1  write request to the driver.
- `spi_rd_req`  out  1  read request to the driver.
- `spi_data`  out  DATA_WITH  word driven to the driver's `data` input.
- `spi_ready`  in  1  driver idle / ready.
- `spi_wr_done`  in  1  driver write complete (pulse).
- `spi_rd_data_vld`  in  1  driver readback valid (pulse).
- `spi_rd_data`  in  READ_DATA_WITH  readback, device A.
- `spi_rd_data_b`  in  READ_DATA_WITH  readback, device B.
- `rsp_valid`  out  1  one-cycle response strobe; issued for read commands only.
- `rsp_data`  out  READ_DATA_WITH  device A readback.
- `rsp_data_b`  out  READ_DATA_WITH  device B readback.
- `rsp_timeout`  out  1  qualifies `rsp_valid`: the read timed out.
- `err_timeout`  out  1  sticky flag: any transaction timed out.
- `err_clr`  in  1  clears `err_timeout`.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  number of entries in the FIFO.
- `busy`  out  1  `state != IDLE || fifo_level != 0`.

## Operation

FIFO:
- Entry is `{cmd_rd, cmd_data}`.
- Push when `cmd_valid && cmd_ready`. A push is blocked when full, even if a pop occurs in the same cycle.
- Simultaneous push and pop leaves `fifo_level` unchanged.
- Pointers wrap modulo FIFO_DEPTH.

FSM (all registered):
- IDLE: if FIFO non-empty, pop. Latch the data into the `spi_data` register and the type into `cur_rd`. Go to ISSUE.
- ISSUE: wait for `spi_ready`=1, with no time limit. Then go to REQ.
- REQ: exactly one cycle. `spi_rd_req = cur_rd`, `spi_wr_req = !cur_rd`. Clear the timeout counter. Go to WAIT.
- WAIT, write command: `spi_wr_done` -> IDLE.
- WAIT, read command: `spi_rd_data_vld` -> capture both readback words, `rsp_timeout`=0 -> IDLE.
- WAIT, timeout: the counter increments each WAIT cycle. If no completion by count TIMEOUT-1:
  - set `err_timeout`;
  - for a read, emit a response with `rsp_data`/`rsp_data_b`=0 and `rsp_timeout`=1;
  - go to IDLE.
- A completion arriving in the same cycle as the timeout terminal count wins: treated as a normal completion, no error.
- Completion pulses seen outside WAIT, and pulses of the wrong type in WAIT (`spi_wr_done` during a read, `spi_rd_data_vld` during a write), are ignored.
- `err_timeout`: a set on timeout in the same cycle as `err_clr` wins, leaving the flag 1.
- `spi_data` holds its value from IDLE->ISSUE until the next pop.

## Timing

Reset values:
- All outputs 0, except `cmd_ready`=1.
- FIFO empty, state IDLE, `spi_data`=0, counter 0.

Reset mid-transaction:
- Flushes the FIFO, drops any pending response, returns to IDLE.
- The driver is reset separately; this block does not abort it.

Latency:
- Push at cycle N into an empty FIFO: `fifo_level`=1 at N+1.
- Pop at N+1; ISSUE at N+2.
- If `spi_ready`=1, REQ (request high) at N+3.
- `rsp_valid` is registered: high in the cycle after the completion pulse, for exactly one cycle.
- The FSM is back in IDLE in that same cycle.
- Minimum spacing between requests = 4 cycles plus the driver's busy time.

Response bus:
- `rsp_data`/`rsp_data_b`/`rsp_timeout` hold until the next response.
- The response has no backpressure.

## Test plan

- Reset, then push write 0x1234567 with `spi_ready`=1 -> `spi_wr_req` pulses once at N+3 with `spi_data`=0x1234567. `spi_wr_done` 5 cycles later -> `busy` falls and `rsp_valid` stays 0.
- Read command; driver returns A=0x0ABCDEF, B=0x1555555 with `spi_rd_data_vld` -> `rsp_valid` for one cycle, `rsp_data`=0x0ABCDEF, `rsp_data_b`=0x1555555, `rsp_timeout`=0.
- Push 9 commands back to back with `spi_ready`=0 -> `cmd_ready`=0 after 8 accepts, `fifo_level`=8. Release `spi_ready` -> all 8 are issued in FIFO order with the correct types.
- Read with no completion, TIMEOUT=16 -> `rsp_valid` with `rsp_timeout`=1, data 0, `err_timeout`=1. Assert `err_clr` -> `err_timeout` is 0 next cycle. Completion on the terminal count cycle -> normal response, no error.
- Assert `rst` while in WAIT with 3 entries queued -> next cycle `fifo_level`=0, state IDLE, all requests and `rsp_valid` 0, `cmd_ready`=1. A stray `spi_wr_done` afterwards is ignored.
